// File: rtl/cdc_fifo_pkt_guard_if.sv
// Valid/ready packet stream (payload + last flag) used on both sides of the guard.
interface cdc_fifo_pkt_guard_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             last;
    logic             valid;
    logic             ready;

    modport master (output data, last, valid, input ready);
    modport slave  (input data, last, valid, output ready);
endinterface

// File: rtl/cdc_fifo_pkt_guard.sv
// Store-and-forward guard behind the clearable CDC FIFO: a packet is released only
// once its last beat is buffered; oversized or clear-interrupted packets are dropped.
//
// state   | meaning
// FILL    | collecting beats of the current packet into the buffer
// DRAIN   | emitting the complete buffered packet, input stalled
// DISCARD | oversized packet, swallowing beats until its last one (or a clear)
module cdc_fifo_pkt_guard #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_pending_i,
    cdc_fifo_pkt_guard_if.slave   in_s,
    cdc_fifo_pkt_guard_if.master  out_m,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output logic                  overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_IDX = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, DRAIN, DISCARD} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        len;
    logic [AW-1:0]      rptr;
    logic               accept;
    logic               out_fire;
    logic [CNT_WIDTH-1:0] drop_inc;

    assign in_s.ready  = (state != DRAIN) && !clear_pending_i;
    assign accept      = in_s.valid && in_s.ready;
    assign out_m.valid = (state == DRAIN);
    assign out_m.data  = mem[rptr];
    assign out_m.last  = ({1'b0, rptr} == len - 1'b1);
    assign out_fire    = out_m.valid && out_m.ready;

    // Saturating increment: the counter sticks at all-ones.
    assign drop_inc = (&drop_cnt_o) ? drop_cnt_o : drop_cnt_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (state == FILL && accept)
            mem[wptr[AW-1:0]] <= in_s.data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= FILL;
            wptr       <= '0;
            rptr       <= '0;
            len        <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= 1'b0;
            case (state)
                FILL: begin
                    if (clear_pending_i) begin
                        if (wptr != '0) begin
                            drop_cnt_o <= drop_inc;
                            wptr       <= '0;
                        end
                    end else if (accept) begin
                        wptr <= wptr + 1'b1;
                        if (in_s.last) begin
                            len   <= wptr + 1'b1;
                            rptr  <= '0;
                            state <= DRAIN;
                        end else if (wptr == FULL_IDX) begin
                            state      <= DISCARD;
                            overflow_o <= 1'b1;
                            drop_cnt_o <= drop_inc;
                            wptr       <= '0;
                        end
                    end
                end
                // A complete packet always leaves in full, so clears are ignored here.
                DRAIN: begin
                    if (out_fire) begin
                        rptr <= rptr + 1'b1;
                        if (out_m.last) begin
                            wptr  <= '0;
                            state <= FILL;
                        end
                    end
                end
                DISCARD: begin
                    if (clear_pending_i || (accept && in_s.last))
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_fifo_pkt_guard.sv
// Directed bench for cdc_fifo_pkt_guard: expected beats go into a scoreboard queue,
// an independent monitor pops and compares on every output handshake.
module tb_cdc_fifo_pkt_guard;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int CNT_WIDTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic overflow;
    logic bp_on = 1'b0;
    logic bp_phase = 1'b0;
    logic rdy_fixed = 1'b1;

    int checks = 0;
    int failures = 0;
    int ov_count = 0;
    logic [8:0] exp_q[$];

    logic       mon_stalled = 1'b0;
    logic [8:0] mon_held = '0;
    logic [8:0] mon_got;
    logic [8:0] mon_exp;

    cdc_fifo_pkt_guard_if #(.WIDTH(WIDTH)) in_if ();
    cdc_fifo_pkt_guard_if #(.WIDTH(WIDTH)) out_if ();

    assign out_if.ready = bp_on ? bp_phase : rdy_fixed;

    cdc_fifo_pkt_guard #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clear_pending_i(clear),
        .in_s(in_if),
        .out_m(out_if),
        .drop_cnt_o(drop_cnt),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bp_phase = ~bp_phase;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stalled = 1'b0;
                continue;
            end
            if (overflow) ov_count++;
            mon_got = {out_if.last, out_if.data};
            if (mon_stalled && out_if.valid)
                check("hold_stable", int'(mon_got), int'(mon_held));
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h expected=none", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_beat", int'(mon_got), int'(mon_exp));
                end
            end
            mon_stalled = out_if.valid && !out_if.ready;
            mon_held    = mon_got;
        end
    end

    // Entered and left at posedge+1; returns the number of cycles in_ready was low.
    task automatic drive_beat(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.last  = l;
        @(negedge clk);
        while (!in_if.ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_if.ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] base, input logic [7:0] step,
                            input bit expect_out, output int waited);
        int w;
        logic [7:0] d;
        logic l;
        waited = 0;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i) * step;
            l = (i == n - 1);
            if (expect_out) exp_q.push_back({l, d});
            drive_beat(d, l, w);
            waited += w;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_if.valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int cyc;
        int n;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_if.ready, 1);
        @(posedge clk);
        #1;

        // Basic forward: 0x11, 0x22, 0x33
        send_pkt(3, 8'h11, 8'h11, 1, w);
        @(negedge clk);
        check("latency_valid", out_if.valid, 1);
        check("in_ready_busy", in_if.ready, 0);
        cyc = 0;
        while (out_if.valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("drain_cycles", cyc, 3);
        check("basic_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;

        // Backpressure: out_ready toggles every cycle
        bp_on = 1'b1;
        send_pkt(3, 8'h11, 8'h11, 1, w);
        n = 0;
        do begin
            @(negedge clk);
            if (out_if.valid) check("in_ready_drain", in_if.ready, 0);
            n++;
        end while (out_if.valid && n < 100);
        check("in_ready_after", in_if.ready, 1);
        check("bp_drained", exp_q.size(), 0);
        bp_on = 1'b0;
        @(posedge clk);
        #1;

        // Exactly DEPTH beats is legal
        send_pkt(16, 8'h80, 8'h01, 1, w);
        wait_drain("full_pkt_drain");
        check("full_drop_cnt", drop_cnt, 0);

        // DEPTH+1 beats: dropped, one overflow pulse, input never stalls
        ov_count = 0;
        send_pkt(17, 8'hC0, 8'h01, 0, w);
        check("ovf_in_ready_waits", w, 0);
        @(negedge clk);
        check("ovf_pulses", ov_count, 1);
        check("ovf_drop_cnt", drop_cnt, 1);
        check("ovf_no_output", out_if.valid, 0);
        check("ovf_back_to_fill", in_if.ready, 1);
        @(posedge clk);
        #1;

        // Clear mid-fill
        drive_beat(8'h01, 1'b0, w);
        drive_beat(8'h02, 1'b0, w);
        clear = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("clr_in_ready", in_if.ready, 0);
            check("clr_no_output", out_if.valid, 0);
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        check("clr_drop_cnt", drop_cnt, 2);
        send_pkt(1, 8'hAA, 8'h00, 1, w);
        @(negedge clk);
        check("single_valid", out_if.valid, 1);
        check("single_last", out_if.last, 1);
        wait_drain("single_drain");

        // Clear during a stalled drain does not cut the packet
        rdy_fixed = 1'b0;
        send_pkt(4, 8'h41, 8'h01, 1, w);
        clear = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("drain_clr_valid", out_if.valid, 1);
            check("drain_clr_in_ready", in_if.ready, 0);
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("drain_clr_drain");
        check("drain_clr_drop_cnt", drop_cnt, 2);

        // Saturation of a 2-bit drop counter
        repeat (5) begin
            drive_beat(8'h55, 1'b0, w);
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
        check("sat_drop_cnt", drop_cnt, 3);

        // Reset mid-fill abandons the partial packet silently
        drive_beat(8'h71, 1'b0, w);
        drive_beat(8'h72, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        check("mid_rst_out_valid", out_if.valid, 0);
        check("mid_rst_in_ready", in_if.ready, 1);
        @(posedge clk);
        #1;
        send_pkt(1, 8'h5A, 8'h00, 1, w);
        wait_drain("post_rst_drain");

        // Clear while discarding leaves DISCARD without a second count
        ov_count = 0;
        for (int i = 0; i < 16; i++) drive_beat(8'(i), 1'b0, w);
        @(negedge clk);
        check("disc_ovf_pulses", ov_count, 1);
        check("disc_drop_cnt", drop_cnt, 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        check("disc_clr_drop_cnt", drop_cnt, 1);
        send_pkt(2, 8'h61, 8'h01, 1, w);
        wait_drain("disc_clr_drain");

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
